// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch-side bus bundle.
//   imem_req_*  : request channel to instruction memory (valid/ready)
//   imem_rsp_*  : in-order response channel from memory (valid only)
//   if_*        : instruction handoff to decode (valid/ready)
// master = fetch controller, slave = memory/decode environment.
interface instr_fetch_if #(
  parameter int mem_size = 32
);
  logic                imem_req_valid;
  logic [mem_size-1:0] imem_req_addr;
  logic                imem_req_ready;
  logic                imem_rsp_valid;
  logic [31:0]         imem_rsp_data;
  logic                if_valid;
  logic [31:0]         if_instr;
  logic [mem_size-1:0] if_pc;
  logic                if_ready;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: issues in-order fetches at pc_in, buffers returned
// instructions with their PCs in a DEPTH-entry queue and hands them to decode.
//   clk, reset : clock, async active-high reset
//   pc_in      : current PC
//   PC_write   : PC load enable (request accepted or redirect)
//   flush      : redirect; drops queue contents and owed responses
//   bus        : imem request/response and decode handshake (master side)
module instr_fetch_ctrl #(
  parameter int mem_size = 32,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [mem_size-1:0] pc_in,
  output logic                PC_write,
  input  logic                flush,
  instr_fetch_if.master       bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][mem_size-1:0] pc_q;
  logic [DEPTH-1:0][31:0]         instr_q;
  logic [DEPTH-1:0]               filled_q;

  logic [AW-1:0] head_q, head_d, alloc_q, alloc_d, fill_q, fill_d;
  // pend counts allocated-but-unfilled entries; it is exactly what a
  // flush turns into owed (discarded) responses.
  logic [CW-1:0] occ_q, occ_d, pend_q, pend_d, discard_q, discard_d;
  logic [CW:0]   total;
  logic          fire, deq, rsp_keep;

  assign total              = {1'b0, occ_q} + {1'b0, discard_q};
  assign bus.imem_req_valid = !reset && !flush && (total < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = pc_in;
  assign fire               = bus.imem_req_valid && bus.imem_req_ready;
  assign PC_write           = !reset && (fire || flush);

  assign bus.if_valid = (occ_q != '0) && filled_q[head_q] && !flush;
  assign bus.if_instr = instr_q[head_q];
  assign bus.if_pc    = pc_q[head_q];
  assign deq          = bus.if_valid && bus.if_ready;

  // A response is kept only when nothing is owed to flushed requests.
  assign rsp_keep = bus.imem_rsp_valid && (discard_q == '0) && !flush;

  always_comb begin
    head_d    = head_q;
    alloc_d   = alloc_q;
    fill_d    = fill_q;
    occ_d     = occ_q;
    pend_d    = pend_q;
    discard_d = discard_q;
    if (flush) begin
      head_d    = alloc_q;
      fill_d    = alloc_q;
      occ_d     = '0;
      pend_d    = '0;
      discard_d = discard_q + pend_q - CW'(bus.imem_rsp_valid);
    end else begin
      if (fire) alloc_d = alloc_q + AW'(1);
      if (deq)  head_d  = head_q + AW'(1);
      occ_d = occ_q + CW'(fire) - CW'(deq);
      if (bus.imem_rsp_valid && discard_q != '0) discard_d = discard_q - CW'(1);
      if (rsp_keep) fill_d = fill_q + AW'(1);
      pend_d = pend_q + CW'(fire) - CW'(rsp_keep);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      instr_q   <= '0;
      filled_q  <= '0;
      head_q    <= '0;
      alloc_q   <= '0;
      fill_q    <= '0;
      occ_q     <= '0;
      pend_q    <= '0;
      discard_q <= '0;
    end else begin
      head_q    <= head_d;
      alloc_q   <= alloc_d;
      fill_q    <= fill_d;
      occ_q     <= occ_d;
      pend_q    <= pend_d;
      discard_q <= discard_d;
      if (flush) begin
        filled_q <= '0;
      end else begin
        if (fire) begin
          pc_q[alloc_q]     <= pc_in;
          filled_q[alloc_q] <= 1'b0;
        end
        if (rsp_keep) begin
          instr_q[fill_q]  <= bus.imem_rsp_data;
          filled_q[fill_q] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (occ_q <= CW'(DEPTH));
      assert (discard_q <= CW'(DEPTH));
      assert (pend_q <= occ_q);
    end
  end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        PC_write;
  logic        flush;
  int          n_chk = 0;
  int          n_fail = 0;

  instr_fetch_if #(.mem_size(32)) bus ();

  instr_fetch_ctrl #(.mem_size(32), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_in    (pc_in),
    .PC_write (PC_write),
    .flush    (flush),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] pc, last_pc;
    int          fires;
    logic        pend;

    reset = 1'b1; flush = 1'b0; pc_in = 32'h0;
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = 32'h0; bus.if_ready = 1'b0;
    smp();
    chk("rst_pcw", PC_write, 0);
    chk("rst_reqv", bus.imem_req_valid, 0);
    step(); step();
    reset = 1'b0; bus.imem_req_ready = 1'b0;
    smp();
    chk("post_rst_reqv", bus.imem_req_valid, 1);
    chk("post_rst_ifv", bus.if_valid, 0);
    step();

    // single fetch
    pc_in = 32'h100; bus.imem_req_ready = 1'b1;
    smp();
    chk("sf_pcw_c0", PC_write, 1);
    chk("sf_addr", bus.imem_req_addr, 32'h100);
    step();
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h00500093;
    smp();
    chk("sf_ifv_c1", bus.if_valid, 0);
    chk("sf_pcw_c1", PC_write, 0);
    step();
    bus.imem_rsp_valid = 1'b0; bus.if_ready = 1'b1;
    smp();
    chk("sf_ifv_c2", bus.if_valid, 1);
    chk("sf_pc_c2", bus.if_pc, 32'h100);
    chk("sf_instr_c2", bus.if_instr, 32'h00500093);
    step();
    bus.if_ready = 1'b0;
    smp();
    chk("sf_ifv_c3", bus.if_valid, 0);
    chk("sf_occ_c3", dut.occ_q, 0);

    // backpressure: 1-cycle memory, decode stalled
    pc = 32'h0; last_pc = 32'h0; fires = 0; pend = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      pc_in = pc; bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = pend; bus.imem_rsp_data = 32'hA000_0000 | last_pc;
      smp();
      pend = PC_write;
      if (PC_write) begin
        last_pc = pc;
        fires++;
        pc = pc + 32'd4;
      end
    end
    step();
    bus.imem_rsp_valid = 1'b0;
    smp();
    chk("bp_fires", fires, 4);
    chk("bp_reqv", bus.imem_req_valid, 0);
    chk("bp_pcw", PC_write, 0);
    step();
    bus.imem_req_ready = 1'b0; bus.if_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("bp_ifv", bus.if_valid, 1);
      chk("bp_pc", bus.if_pc, 32'(4 * i));
      chk("bp_instr", bus.if_instr, 32'hA000_0000 | 32'(4 * i));
      step();
    end
    smp();
    chk("bp_drained", bus.if_valid, 0);

    // flush with two requests in flight
    step();
    pc_in = 32'h200; bus.imem_req_ready = 1'b1;
    smp();
    chk("fl_pcw_a", PC_write, 1);
    step();
    pc_in = 32'h204;
    smp();
    chk("fl_pcw_b", PC_write, 1);
    step();
    pc_in = 32'h300; flush = 1'b1;
    smp();
    chk("fl_reqv", bus.imem_req_valid, 0);
    chk("fl_pcw", PC_write, 1);
    step();
    flush = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hBAD0_0200;
    smp();
    chk("fl_disc2", dut.discard_q, 2);
    chk("fl_pcw_tgt", PC_write, 1);
    step();
    bus.imem_req_ready = 1'b0; bus.imem_rsp_data = 32'hBAD0_0204;
    smp();
    chk("fl_disc1", dut.discard_q, 1);
    chk("fl_ifv_d1", bus.if_valid, 0);
    step();
    bus.imem_rsp_data = 32'h0000_0300;
    smp();
    chk("fl_disc0", dut.discard_q, 0);
    chk("fl_ifv_d2", bus.if_valid, 0);
    step();
    bus.imem_rsp_valid = 1'b0;
    smp();
    chk("fl_ifv", bus.if_valid, 1);
    chk("fl_pc", bus.if_pc, 32'h300);
    chk("fl_instr", bus.if_instr, 32'h0000_0300);
    step();

    // flush and response together
    pc_in = 32'h400; bus.imem_req_ready = 1'b1; bus.if_ready = 1'b0;
    step();
    bus.imem_req_ready = 1'b0; flush = 1'b1;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0400;
    smp();
    chk("fr_pcw", PC_write, 1);
    chk("fr_ifv", bus.if_valid, 0);
    step();
    flush = 1'b0; bus.imem_rsp_valid = 1'b0;
    smp();
    chk("fr_disc", dut.discard_q, 0);
    chk("fr_occ", dut.occ_q, 0);
    chk("fr_ifv_after", bus.if_valid, 0);

    // memory stall
    pc_in = 32'h500; bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      smp();
      chk("ms_reqv", bus.imem_req_valid, 1);
      chk("ms_pcw", PC_write, 0);
      chk("ms_addr", bus.imem_req_addr, 32'h500);
    end

    // reset with three entries allocated, head filled
    step();
    pc_in = 32'h600; bus.imem_req_ready = 1'b1;
    step();
    pc_in = 32'h604; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h1111_1111;
    step();
    pc_in = 32'h608; bus.imem_rsp_valid = 1'b0;
    step();
    bus.imem_req_ready = 1'b0;
    smp();
    chk("mr_occ_pre", dut.occ_q, 3);
    chk("mr_ifv_pre", bus.if_valid, 1);
    chk("mr_pc_pre", bus.if_pc, 32'h600);
    step();
    reset = 1'b1; bus.imem_req_ready = 1'b1;
    smp();
    chk("mr_occ", dut.occ_q, 0);
    chk("mr_ifv", bus.if_valid, 0);
    chk("mr_instr", bus.if_instr, 0);
    chk("mr_pc", bus.if_pc, 0);
    chk("mr_pcw", PC_write, 0);
    step();
    smp();
    chk("mr_pcw_hold", PC_write, 0);
    chk("mr_reqv_hold", bus.imem_req_valid, 0);
    step();
    reset = 1'b0; bus.imem_req_ready = 1'b0;
    smp();
    chk("mr_reqv_rel", bus.imem_req_valid, 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction fetch controller sitting between the program counter and instruction memory. It consumes the current PC, issues in-order fetch requests with a valid/ready handshake, and buffers returned instructions with their PCs in a DEPTH-entry queue. It presents them to decode through a valid/ready interface. It drives `PC_write` back to the program counter so the PC advances only when a fetch is accepted or a redirect occurs.

## Interface
Parameters:
- `mem_size`, 32: address width, for both PC and memory address.
- `DEPTH`, 4: fetch queue entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc_in`  in  mem_size  current PC from the program counter.
- `PC_write`  out  1  PC load enable; 1 means the PC loads its next value.
- `flush`  in  1  redirect (branch/jump taken or mispredict); the PC loads the target this cycle.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  mem_size  fetch address; equals `pc_in`.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_rsp_valid`  in  1  instruction returned; in order, at most one per cycle.
- `imem_rsp_data`  in  32  returned instruction.
- `if_valid`  out  1  instruction available to decode.
- `if_instr`  out  32  head instruction.
- `if_pc`  out  mem_size  PC of the head instruction.
- `if_ready`  in  1  decode accepts the head.

## Operation
- Queue entries hold {pc, instr, filled}. Pointers:
  - head: dequeue.
  - alloc: next free entry.
  - fill: oldest unfilled entry.
- Counters: `occ` (allocated entries, 0..DEPTH) and `discard` (responses still owed for flushed requests, 0..DEPTH).
- `imem_req_valid = !flush && (occ + discard < DEPTH)`. The request does not depend on `imem_req_ready`.
- Request fire (`imem_req_valid && imem_req_ready`):
  - allocate the entry at alloc, with pc = `pc_in` and filled = 0;
  - alloc++ and occ++.
- `PC_write = req_fire || flush`. This is combinational.
- Response handling:
  - If `discard > 0`, the response is dropped and `discard` decrements.
  - Otherwise it writes instr into the fill entry, sets filled = 1, and fill++.
- `if_valid = (occ > 0) && head.filled && !flush`. `if_instr`/`if_pc` are the head entry fields.
- Dequeue (`if_valid && if_ready`): head++ and occ--. Fire and dequeue in the same cycle net occ unchanged.
- Flush:
  - Every queue entry is invalidated, occ becomes 0, and head = alloc = fill.
  - `discard_next = discard + unfilled_entries - (imem_rsp_valid ? 1 : 0)`.
  - On a flush cycle, no request is issued and no dequeue occurs.
- A response arriving with no outstanding request is a protocol violation; behaviour is undefined and the bench must not generate it.
- Pointers wrap modulo DEPTH. Counters never exceed DEPTH; an overflow is an assertion failure.

## Timing
- Reset, asynchronous, applied at any time, including mid-fetch:
  - occ, discard and all pointers go to 0;
  - all entry fields go to 0;
  - `if_valid`=0, `if_instr`=0, `if_pc`=0;
  - `imem_req_valid`=1 once reset deasserts, since the queue is empty.
  - While reset is asserted, `PC_write`=0 and `imem_req_valid`=0.
- In-flight responses lost to reset are not tracked. The memory is reset alongside this block.
- Request latency: `PC_write` asserts in the same cycle as the request fire.
- Response accepted at edge N: `if_valid`=1 during cycle N+1 at earliest. Minimum fetch-to-decode latency is 2 cycles with a 1-cycle memory.
- With DEPTH=4, a 1-cycle memory and `if_ready` held at 1, the block sustains 1 instruction per cycle.
- Full queue (`occ + discard == DEPTH`): `imem_req_valid`=0 and `PC_write`=0, so the PC holds.
- Flush and response in the same cycle: the response is dropped.
- Flush and `imem_req_ready` in the same cycle: no fire, because valid is low.

## Test plan
- Reset mid-operation:
  - Stimulus: assert reset with 3 entries allocated.
  - Required: the next cycle shows occ=0, `if_valid`=0, `if_instr`=0, `if_pc`=0, and `PC_write`=0.
- Single fetch:
  - Stimulus: pc_in=0x100, ready=1, response 0x00500093 one cycle later.
  - Required: `PC_write`=1 in cycle 0; `if_valid`=1 with `if_pc`=0x100 and `if_instr`=0x00500093 in cycle 2.
- Backpressure:
  - Stimulus: `if_ready`=0, 1-cycle memory, PCs 0x0, 0x4, 0x8, 0xC.
  - Required: exactly 4 fires; `imem_req_valid` then stays 0 and `PC_write`=0.
  - After releasing `if_ready`: the head order is 0x0, 0x4, 0x8, 0xC.
- Flush with in-flight requests:
  - Stimulus: 2 requests outstanding, assert flush.
  - Required: the next 2 responses are dropped (`if_valid` stays 0), `discard` is 2→1→0, and the first post-flush PC is delivered.
- Simultaneous flush and response:
  - Stimulus: 1 unfilled entry, `imem_rsp_valid`=1 and flush together.
  - Required: discard=0, the response is not delivered, and `PC_write`=1.
- Memory stall:
  - Stimulus: `imem_req_ready`=0 for 5 cycles with `imem_req_valid`=1.
  - Required: `PC_write`=0 throughout and `imem_req_addr` stable at `pc_in`.
